// File: rtl/cpuarb_pkg.sv
// cpuarb_tdm shared package: width helpers, defaults, owner decode.
// Optional wait stretching is selected by the ARB_WAIT_EN macro.
package cpuarb_pkg;

  localparam int MAXCPU     = 8;
  localparam int D_NCPU     = 3;
  localparam int D_NSLOT    = 4;
  localparam int D_SLOTLEN  = 4;
  localparam int D_AW       = 16;
  localparam int D_DW       = 8;
  localparam int D_WAIT_MAX = 15;

  // Counter width for a modulus of n, never narrower than one bit
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot owner vector for a slot; idle slots map to all zeros
  function automatic logic [MAXCPU-1:0] slot_onehot(
    input int slot,
    input int ncpu
  );
    logic [MAXCPU-1:0] oh;
    oh = '0;
    if (slot < ncpu && slot < MAXCPU)
      oh = MAXCPU'(1) << slot;
    return oh;
  endfunction

endpackage

// File: rtl/cpuarb_tdm_timer.sv
// arb_slot_timer: phase, slot and (with ARB_WAIT_EN) wait counters.
// o_advance marks the cycle on which the current slot completes.
module arb_slot_timer
  import cpuarb_pkg::*;
#(
  parameter  int NCPU     = D_NCPU,
  parameter  int NSLOT    = D_NSLOT,
  parameter  int SLOTLEN  = D_SLOTLEN,
  parameter  int WAIT_MAX = D_WAIT_MAX,
  localparam int PW       = cw(SLOTLEN),
  localparam int SW       = cw(NSLOT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wait,
  output logic [PW-1:0] o_phase,
  output logic [SW-1:0] o_slot,
  output logic          o_owner_valid,
  output logic          o_last_phase,
  output logic          o_advance,
  output logic          o_timeout
);

  logic [PW-1:0] r_phase;
  logic [SW-1:0] r_slot;

  assign o_phase       = r_phase;
  assign o_slot        = r_slot;
  assign o_last_phase  = (r_phase == PW'(SLOTLEN - 1));
  assign o_owner_valid = (int'(r_slot) < NCPU);

`ifdef ARB_WAIT_EN
  localparam int WW = cw(WAIT_MAX + 1);

  logic [WW-1:0] r_wait;
  logic          w_full;
  logic          w_hold;

  assign w_full    = (r_wait == WW'(WAIT_MAX));
  assign w_hold    = o_last_phase & o_owner_valid & i_wait & ~w_full;
  assign o_advance = o_last_phase & ~w_hold;
  assign o_timeout = o_last_phase & o_owner_valid & i_wait & w_full;

  // Count held cycles of the owned last phase; cleared as a slot ends
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_wait <= '0;
    else if (o_advance)
      r_wait <= '0;
    else if (w_hold)
      r_wait <= r_wait + WW'(1);
  end
`else
  logic w_unused_wait;

  assign w_unused_wait = i_wait;
  assign o_advance     = o_last_phase;
  assign o_timeout     = 1'b0;
`endif

  // Step phase each cycle; step slot and wrap phase when a slot ends
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_slot  <= '0;
    end else if (o_advance) begin
      r_phase <= '0;
      r_slot  <= (r_slot == SW'(NSLOT - 1)) ? '0 : r_slot + SW'(1);
    end else if (!o_last_phase) begin
      r_phase <= r_phase + PW'(1);
    end
  end

endmodule

// File: rtl/cpuarb_tdm.sv
// cpuarb_tdm: TDM arbiter sharing one device bus among NCPU CPUs.
// Define ARB_WAIT_EN to let DEV_WAIT stretch an owned slot.
module cpuarb_tdm
  import cpuarb_pkg::*;
#(
  parameter  int NCPU     = D_NCPU,
  parameter  int NSLOT    = D_NSLOT,
  parameter  int SLOTLEN  = D_SLOTLEN,
  parameter  int AW       = D_AW,
  parameter  int DW       = D_DW,
  parameter  int WAIT_MAX = D_WAIT_MAX,
  localparam int SW       = cw(NSLOT)
) (
  input  logic               MCLK,
  input  logic               RESET_N,
  output logic [NCPU-1:0]    CPU_CE,
  input  logic [NCPU*AW-1:0] CPU_AD,
  input  logic [NCPU-1:0]    CPU_RD,
  input  logic [NCPU-1:0]    CPU_WR,
  input  logic [NCPU*DW-1:0] CPU_DO,
  output logic [NCPU*DW-1:0] CPU_DI,
  output logic [NCPU-1:0]    CPU_DV,
  output logic               DEV_CE,
  output logic [AW-1:0]      DEV_AD,
  output logic               DEV_RD,
  output logic               DEV_WR,
  output logic [DW-1:0]      DEV_DI,
  input  logic [DW-1:0]      DEV_DO,
  input  logic               DEV_DV,
  input  logic               DEV_WAIT,
  output logic [SW-1:0]      SLOT
);

  localparam int PW = cw(SLOTLEN);

  logic [PW-1:0]     w_phase;
  logic [SW-1:0]     w_slot;
  logic              w_owner_valid;
  logic              w_last_phase;
  logic              w_adv;
  logic              w_timeout;
  logic              w_cap;
  logic              w_wr;
  logic [MAXCPU-1:0] w_oh;
  logic              w_unused_oh;
  logic [NCPU-1:0]   w_sel;

  logic [NCPU-1:0]    r_ce;
  logic [NCPU-1:0]    r_dv;
  logic [NCPU*DW-1:0] r_di;

  arb_slot_timer #(
    .NCPU     (NCPU),
    .NSLOT    (NSLOT),
    .SLOTLEN  (SLOTLEN),
    .WAIT_MAX (WAIT_MAX)
  ) u_timer (
    .clk           (MCLK),
    .rst_n         (RESET_N),
    .i_wait        (DEV_WAIT),
    .o_phase       (w_phase),
    .o_slot        (w_slot),
    .o_owner_valid (w_owner_valid),
    .o_last_phase  (w_last_phase),
    .o_advance     (w_adv),
    .o_timeout     (w_timeout)
  );

  assign w_oh        = slot_onehot(int'(w_slot), NCPU);
  assign w_unused_oh = ^w_oh;
  assign w_sel       = w_owner_valid ? w_oh[NCPU-1:0] : '0;
  assign w_cap       = w_last_phase & w_adv;

  assign SLOT   = w_slot;
  assign CPU_CE = r_ce;
  assign CPU_DI = r_di;
  assign CPU_DV = r_dv;
  assign DEV_CE = (w_phase != '0);
  assign DEV_WR = w_wr & (w_phase != '0);

  // Route the owner's bus onto the device side; idle slots drive zero
  always_comb begin
    DEV_AD = '0;
    DEV_RD = 1'b0;
    DEV_DI = '0;
    w_wr   = 1'b0;
    for (int n = 0; n < NCPU; n++) begin
      if (w_sel[n]) begin
        DEV_AD = CPU_AD[n*AW +: AW];
        DEV_RD = CPU_RD[n];
        DEV_DI = CPU_DO[n*DW +: DW];
        w_wr   = CPU_WR[n];
      end
    end
  end

  // Capture device data for the owner and emit its CE one cycle later
  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      r_ce <= '0;
      r_di <= '0;
      r_dv <= '0;
    end else begin
      r_ce <= w_cap ? w_sel : '0;
      for (int n = 0; n < NCPU; n++) begin
        if (w_cap && w_sel[n]) begin
          r_di[n*DW +: DW] <= w_timeout ? '1 : DEV_DO;
          r_dv[n]          <= DEV_DV & ~w_timeout;
        end
      end
    end
  end

endmodule
